// File: rtl/life_fb_scheduler.sv
// Framebuffer port arbiter and generation scheduler for a Game-of-Life display.
// Display owns the cell memory inside the active window; the life engine gets it during blanking.
module life_fb_scheduler #(
    parameter int unsigned HLEN           = 1280,
    parameter int unsigned VHEIGHT        = 1024,
    parameter int unsigned CELL_SHIFT     = 3,
    parameter int unsigned FRAMES_PER_GEN = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        frame,
    input  logic        run,
    input  logic        single_step,
    input  logic        eng_req,
    input  logic        eng_we,
    input  logic [14:0] eng_addr,
    input  logic        eng_wdata,
    input  logic        eng_done,
    input  logic        mem_rdata,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic        mem_wdata,
    output logic        eng_gnt,
    output logic        eng_rvalid,
    output logic        eng_rdata,
    output logic        step,
    output logic        busy,
    output logic        pixel_on,
    output logic [15:0] gen_count
);

    localparam int unsigned XW        = 11;
    localparam int unsigned AW        = 15;
    localparam int unsigned GW        = 16;
    localparam int unsigned FCW       = 8;
    localparam int unsigned GRID_COLS = HLEN >> CELL_SHIFT;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        COUNT  = 2'd1,
        STEP   = 2'd2,
        BUSY   = 2'd3
    } state_t;

    logic          in_window;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] row_base;
    logic [AW-1:0] disp_addr;
    logic          win_d;

    state_t         state;
    state_t         state_nxt;
    logic [FCW-1:0] frame_cnt;
    logic [FCW-1:0] frame_cnt_nxt;
    logic           pending;
    logic           pending_nxt;
    logic [GW-1:0]  gen_nxt;
    logic           step_nxt;
    logic           busy_nxt;
    logic           last_frame;

    // Active window test and display cell address
    assign in_window = (x < XW'(HLEN)) && (y < XW'(VHEIGHT));
    assign row       = AW'(y >> CELL_SHIFT);
    assign col       = AW'(x >> CELL_SHIFT);

    // row * GRID_COLS built from shifted partial rows (constant multiplier, no DSP)
    always_comb begin
        row_base = '0;
        for (int i = 0; i < int'(AW); i++) begin
            if (GRID_COLS[i]) begin
                row_base = row_base + (row << i);
            end
        end
    end

    assign disp_addr = row_base + col;

    // Port ownership: display in window, engine in blanking when it asks
    always_comb begin
        eng_gnt   = !in_window && eng_req;
        mem_addr  = in_window ? disp_addr : eng_addr;
        mem_we    = eng_gnt && eng_we;
        mem_wdata = eng_gnt && eng_wdata;
    end

    // Engine read data is forwarded in the cycle the memory returns it
    assign eng_rdata = eng_rvalid && mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            win_d      <= 1'b0;
            pixel_on   <= 1'b0;
            eng_rvalid <= 1'b0;
        end else begin
            win_d      <= in_window;
            pixel_on   <= win_d && mem_rdata;
            eng_rvalid <= eng_gnt && !eng_we;
        end
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAUSED;
        end else begin
            state <= state_nxt;
        end
    end

    assign last_frame = frame_cnt == FCW'(FRAMES_PER_GEN - 1);

    // Scheduler next-state
    always_comb begin
        state_nxt = state;
        case (state)
            PAUSED: begin
                if (run) begin
                    state_nxt = COUNT;
                end else if (pending && frame) begin
                    state_nxt = STEP;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_nxt = PAUSED;
                end else if (frame && last_frame) begin
                    state_nxt = STEP;
                end
            end
            STEP: state_nxt = BUSY;
            BUSY: begin
                if (eng_done) begin
                    state_nxt = run ? COUNT : PAUSED;
                end
            end
            default: state_nxt = PAUSED;
        endcase
    end

    // Scheduler outputs and counters; frame_cnt only advances while counting
    always_comb begin
        frame_cnt_nxt = '0;
        pending_nxt   = pending;
        gen_nxt       = gen_count;
        step_nxt      = state_nxt == STEP;
        busy_nxt      = state_nxt == BUSY;
        case (state)
            PAUSED: begin
                if (!run && pending && frame) begin
                    pending_nxt = 1'b0;
                end else if (single_step) begin
                    pending_nxt = 1'b1;
                end
            end
            COUNT: begin
                if (run && frame && !last_frame) begin
                    frame_cnt_nxt = frame_cnt + 1'b1;
                end else if (run && !frame) begin
                    frame_cnt_nxt = frame_cnt;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    gen_nxt = gen_count + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            pending   <= 1'b0;
            gen_count <= '0;
            step      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            pending   <= pending_nxt;
            gen_count <= gen_nxt;
            step      <= step_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_life_fb_scheduler.sv
// Directed bench for life_fb_scheduler: port arbitration, display latency and generation scheduling.
module tb_life_fb_scheduler;

    logic        clk;
    logic        reset;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame;
    logic        run;
    logic        single_step;
    logic        eng_req;
    logic        eng_we;
    logic [14:0] eng_addr;
    logic        eng_wdata;
    logic        eng_done;
    logic        mem_rdata;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic        mem_wdata;
    logic        eng_gnt;
    logic        eng_rvalid;
    logic        eng_rdata;
    logic        step;
    logic        busy;
    logic        pixel_on;
    logic [15:0] gen_count;

    int total = 0;
    int bad   = 0;

    life_fb_scheduler #(
        .HLEN          (1280),
        .VHEIGHT       (1024),
        .CELL_SHIFT    (3),
        .FRAMES_PER_GEN(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .frame      (frame),
        .run        (run),
        .single_step(single_step),
        .eng_req    (eng_req),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .eng_done   (eng_done),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .eng_gnt    (eng_gnt),
        .eng_rvalid (eng_rvalid),
        .eng_rdata  (eng_rdata),
        .step       (step),
        .busy       (busy),
        .pixel_on   (pixel_on),
        .gen_count  (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
    endtask

    task automatic pulse_single();
        single_step = 1'b1;
        @(negedge clk);
        single_step = 1'b0;
    endtask

    initial begin
        reset = 1'b1; x = 11'd1300; y = 11'd0; frame = 1'b0; run = 1'b0;
        single_step = 1'b0; eng_req = 1'b0; eng_we = 1'b0; eng_addr = 15'd0;
        eng_wdata = 1'b0; eng_done = 1'b0; mem_rdata = 1'b0;
        cyc(); cyc();
        check("rst_step", 32'(step), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_pix", 32'(pixel_on), 32'd0);
        check("rst_rvalid", 32'(eng_rvalid), 32'd0);
        reset = 1'b0;
        cyc();

        // Display fetch: x=16,y=8 -> cell (1,2) -> 162, pixel two cycles later
        x = 11'd16; y = 11'd8; eng_req = 1'b1; eng_addr = 15'd77;
        #1;
        check("win_addr", 32'(mem_addr), 32'd162);
        check("win_gnt", 32'(eng_gnt), 32'd0);
        check("win_we", 32'(mem_we), 32'd0);
        cyc();
        eng_req = 1'b0; x = 11'd1300; mem_rdata = 1'b1;
        cyc();
        check("pix_on", 32'(pixel_on), 32'd1);
        cyc();
        check("pix_off_blank", 32'(pixel_on), 32'd0);
        mem_rdata = 1'b0;

        // Engine read in blanking
        x = 11'd1300; y = 11'd0; eng_req = 1'b1; eng_we = 1'b0; eng_addr = 15'd20479;
        #1;
        check("rd_gnt", 32'(eng_gnt), 32'd1);
        check("rd_addr", 32'(mem_addr), 32'd20479);
        check("rd_we", 32'(mem_we), 32'd0);
        cyc();
        eng_req = 1'b0; mem_rdata = 1'b1;
        #1;
        check("rd_rvalid", 32'(eng_rvalid), 32'd1);
        check("rd_rdata", 32'(eng_rdata), 32'd1);
        cyc();
        mem_rdata = 1'b0;
        check("rd_rvalid_once", 32'(eng_rvalid), 32'd0);

        // Engine write: passes through, never produces rvalid
        eng_req = 1'b1; eng_we = 1'b1; eng_wdata = 1'b1; eng_addr = 15'd5;
        #1;
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_wdata", 32'(mem_wdata), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'd5);
        cyc();
        eng_req = 1'b0; eng_we = 1'b1;
        #1;
        check("wr_no_rvalid", 32'(eng_rvalid), 32'd0);
        check("noreq_we", 32'(mem_we), 32'd0);
        check("noreq_gnt", 32'(eng_gnt), 32'd0);

        // Horizontal and vertical window edges
        eng_req = 1'b1; eng_we = 1'b1; eng_addr = 15'd300;
        x = 11'd1279; y = 11'd0;
        #1;
        check("x1279_gnt", 32'(eng_gnt), 32'd0);
        check("x1279_addr", 32'(mem_addr), 32'd159);
        check("x1279_we", 32'(mem_we), 32'd0);
        cyc();
        x = 11'd1280;
        #1;
        check("x1280_gnt", 32'(eng_gnt), 32'd1);
        check("x1280_addr", 32'(mem_addr), 32'd300);
        cyc();
        x = 11'd0; y = 11'd1023;
        #1;
        check("y1023_gnt", 32'(eng_gnt), 32'd0);
        check("y1023_addr", 32'(mem_addr), 32'd20320);
        cyc();
        y = 11'd1024;
        #1;
        check("y1024_gnt", 32'(eng_gnt), 32'd1);
        cyc();
        eng_req = 1'b0; eng_we = 1'b0; x = 11'd1300; y = 11'd0;
        cyc();

        // Free-running: step on every third frame
        run = 1'b1;
        cyc();
        pulse_frame(); check("run_f1_step", 32'(step), 32'd0);
        pulse_frame(); check("run_f2_step", 32'(step), 32'd0);
        pulse_frame(); check("run_f3_step", 32'(step), 32'd1);
        check("run_f3_busy", 32'(busy), 32'd0);
        cyc();
        check("run_busy", 32'(busy), 32'd1);
        check("run_step_once", 32'(step), 32'd0);
        pulse_done();
        check("run_gen1", 32'(gen_count), 32'd1);
        check("run_idle", 32'(busy), 32'd0);
        pulse_frame(); check("run2_f1_step", 32'(step), 32'd0);
        pulse_frame(); check("run2_f2_step", 32'(step), 32'd0);
        pulse_frame(); check("run2_f3_step", 32'(step), 32'd1);
        cyc();
        pulse_frame();
        check("busy_frame_step", 32'(step), 32'd0);
        check("busy_frame_busy", 32'(busy), 32'd1);
        pulse_done();
        check("run_gen2", 32'(gen_count), 32'd2);

        // Paused: frames and stray eng_done do nothing
        run = 1'b0;
        cyc();
        pulse_frame(); pulse_frame(); pulse_frame();
        check("paused_no_step", 32'(step), 32'd0);
        check("paused_no_busy", 32'(busy), 32'd0);
        pulse_done();
        check("stray_done_gen", 32'(gen_count), 32'd2);

        // Single step waits for a frame, one step only
        pulse_single();
        check("ss_wait_step", 32'(step), 32'd0);
        pulse_frame();
        check("ss_step", 32'(step), 32'd1);
        cyc();
        check("ss_busy", 32'(busy), 32'd1);
        pulse_frame();
        check("ss_busy_frame", 32'(step), 32'd0);
        pulse_single();
        pulse_done();
        check("ss_gen3", 32'(gen_count), 32'd3);
        check("ss_idle", 32'(busy), 32'd0);
        pulse_frame(); check("ss_after1", 32'(step), 32'd0);
        pulse_frame(); check("ss_after2", 32'(step), 32'd0);

        // Run dropped mid-generation: finish, then pause
        run = 1'b1;
        cyc();
        pulse_frame(); pulse_frame(); pulse_frame();
        check("drop_step", 32'(step), 32'd1);
        cyc();
        run = 1'b0;
        cyc();
        check("drop_still_busy", 32'(busy), 32'd1);
        pulse_done();
        check("drop_gen4", 32'(gen_count), 32'd4);
        pulse_frame(); pulse_frame(); pulse_frame();
        check("drop_paused", 32'(step), 32'd0);

        // Reach gen 5, then reset inside BUSY with a read in flight
        pulse_single(); pulse_frame(); cyc();
        pulse_done();
        check("gen5", 32'(gen_count), 32'd5);
        pulse_single(); pulse_frame(); cyc();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1; eng_req = 1'b1; eng_we = 1'b0; eng_addr = 15'd42;
        #1;
        check("rst_gnt_comb", 32'(eng_gnt), 32'd1);
        cyc();
        reset = 1'b0; eng_req = 1'b0; mem_rdata = 1'b1;
        #1;
        check("rst_drop_rvalid", 32'(eng_rvalid), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_gen0", 32'(gen_count), 32'd0);
        cyc();
        mem_rdata = 1'b0;
        pulse_done();
        check("rst_done_ignored", 32'(gen_count), 32'd0);
        pulse_frame();
        check("rst_paused", 32'(step), 32'd0);
        check("rst_paused_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
